// File: rtl/ahb_ri5cy_ifetch_bridge.sv
// ahb_ri5cy_ifetch_bridge: RI5CY instruction-fetch req/gnt/rvalid to AHB-Lite single-word read master.
// Optional AHB_IFETCH_ERR_EN turns AHB error responses into instr_err_o pulses.
module ahb_ri5cy_ifetch_bridge #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      instr_req_i,
    input  logic [AHB_ADDR_WIDTH-1:0] instr_addr_i,
    output logic                      instr_gnt_o,
    output logic                      instr_rvalid_o,
    output logic [AHB_DATA_WIDTH-1:0] instr_rdata_o,
    output logic                      instr_err_o,
    output logic [AHB_ADDR_WIDTH-1:0] haddr_o,
    output logic [1:0]                htrans_o,
    output logic                      hwrite_o,
    output logic [2:0]                hsize_o,
    output logic [2:0]                hburst_o,
    output logic [3:0]                hprot_o,
    output logic                      hmastlock_o,
    output logic [AHB_DATA_WIDTH-1:0] hwdata_o,
    input  logic [AHB_DATA_WIDTH-1:0] hrdata_i,
    input  logic                      hready_i,
    input  logic                      hresp_i
);
    typedef enum logic {IDLE, DATA} state_t;

    state_t                    state_q, state_d;
    logic                      rvalid_q, rvalid_d;
    logic [AHB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      cancel;
    logic                      unused_bits;

    // Both error cycles of a two-cycle AHB error response block a new address phase.
`ifdef AHB_IFETCH_ERR_EN
    assign cancel      = state_q == DATA && hresp_i;
    assign unused_bits = ^instr_addr_i[1:0];
`else
    assign cancel      = 1'b0;
    assign unused_bits = ^{hresp_i, instr_addr_i[1:0]};
`endif

    always_comb begin
        haddr_o     = {instr_addr_i[AHB_ADDR_WIDTH-1:2], 2'b00};
        htrans_o    = (instr_req_i && rstn && !cancel) ? 2'b10 : 2'b00;
        instr_gnt_o = htrans_o[1] & hready_i;
        state_d     = ((state_q == DATA && !hready_i) || instr_gnt_o) ? DATA : IDLE;
        rvalid_d    = state_q == DATA && hready_i;
`ifdef AHB_IFETCH_ERR_EN
        err_d       = rvalid_d && hresp_i;
`else
        err_d       = 1'b0;
`endif
        rdata_d     = rvalid_d ? (err_d ? '0 : hrdata_i) : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign instr_rvalid_o = rvalid_q;
    assign instr_rdata_o  = rdata_q;
    assign instr_err_o    = err_q;
    assign hwrite_o       = 1'b0;
    assign hsize_o        = 3'b010;
    assign hburst_o       = 3'b000;
    assign hprot_o        = 4'b0010;
    assign hmastlock_o    = 1'b0;
    assign hwdata_o       = '0;
endmodule

// File: tb/tb_ahb_ri5cy_ifetch_bridge.sv
// tb_ahb_ri5cy_ifetch_bridge: scoreboarded bench for the instruction-fetch AHB bridge.
// Honours AHB_IFETCH_ERR_EN to choose the expected error behaviour.
module tb_ahb_ri5cy_ifetch_bridge;
`ifdef AHB_IFETCH_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o, haddr_o, hwdata_o, hrdata_i;
    logic [1:0]  htrans_o;
    logic        hwrite_o, hmastlock_o;
    logic [2:0]  hsize_o, hburst_o;
    logic [3:0]  hprot_o;
    logic        hready_i = 1'b1;
    logic        hresp_i = 1'b0;

    int          checks = 0;
    int          passes = 0;
    logic [31:0] exp_q[$];
    logic [31:0] err_addr = 32'h1;
    logic        pend_v;
    logic [31:0] pend_a;

    ahb_ri5cy_ifetch_bridge dut (
        .clk(clk), .rstn(rstn),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o), .hsize_o(hsize_o),
        .hburst_o(hburst_o), .hprot_o(hprot_o), .hmastlock_o(hmastlock_o), .hwdata_o(hwdata_o),
        .hrdata_i(hrdata_i), .hready_i(hready_i), .hresp_i(hresp_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == 32'h1A000080 ? 32'h0000006F : a ^ 32'h1357_9BDF;
    endfunction

    // Slave model: remembers the accepted address phase and returns its word in the data phase.
    always @(posedge clk) begin
        if (!rstn) pend_v <= 1'b0;
        else if (hready_i) begin
            pend_v <= htrans_o[1];
            pend_a <= haddr_o;
        end
        if (instr_gnt_o === 1'b1) exp_q.push_back(instr_addr_i & ~32'h3);
    end
    assign hrdata_i = pend_v ? mem(pend_a) : 32'hDEAD_BEEF;

    always @(negedge clk) begin : monitor
        logic [31:0] a, ed;
        logic        ee;
        if (instr_rvalid_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) $display("FAIL rvalid_unexpected got rdata=%h want no rvalid", instr_rdata_o);
            else begin
                a  = exp_q.pop_front();
                ee = ERR && a == err_addr;
                ed = ee ? 32'h0 : mem(a);
                if (instr_rdata_o !== ed || instr_err_o !== ee)
                    $display("FAIL sb_data addr=%h got rdata=%h err=%b want rdata=%h err=%b", a, instr_rdata_o, instr_err_o, ed, ee);
                else passes++;
            end
        end
    end

    task automatic test_reset();
        rstn = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h40;
        repeat (3) begin
            @(negedge clk); #1;
            checks++; if (htrans_o !== 2'b00) $display("FAIL reset_htrans got=%b want=00", htrans_o); else passes++;
            checks++; if (instr_gnt_o !== 1'b0) $display("FAIL reset_gnt got=%b want=0", instr_gnt_o); else passes++;
            checks++; if (instr_rvalid_o !== 1'b0) $display("FAIL reset_rvalid got=%b want=0", instr_rvalid_o); else passes++;
            checks++; if (instr_rdata_o !== 32'h0) $display("FAIL reset_rdata got=%h want=0", instr_rdata_o); else passes++;
        end
        checks++;
        if ({hwrite_o, hsize_o, hburst_o, hprot_o, hmastlock_o, hwdata_o} !== {1'b0, 3'b010, 3'b000, 4'b0010, 1'b0, 32'h0})
            $display("FAIL consts got w=%b sz=%b b=%b p=%b l=%b wd=%h want 0 010 000 0010 0 0", hwrite_o, hsize_o, hburst_o, hprot_o, hmastlock_o, hwdata_o);
        else passes++;
        @(negedge clk); rstn = 1'b1; instr_req_i = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk); instr_req_i = 1'b1; instr_addr_i = 32'h1A000080; #1;
        checks++; if (instr_gnt_o !== 1'b1) $display("FAIL single_gnt got=%b want=1", instr_gnt_o); else passes++;
        checks++; if (haddr_o !== 32'h1A000080) $display("FAIL single_haddr got=%h want=1a000080", haddr_o); else passes++;
        checks++; if (htrans_o !== 2'b10) $display("FAIL single_htrans got=%b want=10", htrans_o); else passes++;
        @(negedge clk); instr_req_i = 1'b0; #1;
        checks++; if (instr_rvalid_o !== 1'b0) $display("FAIL single_early_rvalid got=%b want=0", instr_rvalid_o); else passes++;
        @(negedge clk); #1;
        checks++; if (instr_rvalid_o !== 1'b1) $display("FAIL single_rvalid got=%b want=1", instr_rvalid_o); else passes++;
        checks++; if (instr_rdata_o !== 32'h6F) $display("FAIL single_rdata got=%h want=0000006f", instr_rdata_o); else passes++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); instr_req_i = i < 4; instr_addr_i = 32'(4 * i); #1;
            checks++; if (instr_gnt_o !== (i < 4)) $display("FAIL b2b_gnt cyc=%0d got=%b want=%b", i, instr_gnt_o, i < 4); else passes++;
            checks++; if (instr_rvalid_o !== (i >= 2 && i < 6)) $display("FAIL b2b_rvalid cyc=%0d got=%b want=%b", i, instr_rvalid_o, i >= 2 && i < 6); else passes++;
            if (i < 4) begin
                checks++; if (haddr_o !== 32'(4 * i)) $display("FAIL b2b_haddr cyc=%0d got=%h want=%h", i, haddr_o, 4 * i); else passes++;
            end
        end
    endtask

    task automatic test_wait_states();
        @(negedge clk); instr_req_i = 1'b1; instr_addr_i = 32'h100; #1;
        checks++; if (instr_gnt_o !== 1'b1) $display("FAIL ws_gnt0 got=%b want=1", instr_gnt_o); else passes++;
        @(negedge clk); instr_addr_i = 32'h104; hready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++; if (instr_gnt_o !== 1'b0) $display("FAIL ws_gnt_wait cyc=%0d got=%b want=0", i, instr_gnt_o); else passes++;
            checks++; if ({haddr_o, htrans_o} !== {32'h104, 2'b10}) $display("FAIL ws_addr_stable cyc=%0d got=%h/%b want=00000104/10", i, haddr_o, htrans_o); else passes++;
            checks++; if (instr_rvalid_o !== 1'b0) $display("FAIL ws_rvalid_wait cyc=%0d got=%b want=0", i, instr_rvalid_o); else passes++;
        end
        @(negedge clk); hready_i = 1'b1; #1;
        checks++; if (instr_gnt_o !== 1'b1) $display("FAIL ws_gnt1 got=%b want=1", instr_gnt_o); else passes++;
        checks++; if (instr_rvalid_o !== 1'b0) $display("FAIL ws_rvalid_n3 got=%b want=0", instr_rvalid_o); else passes++;
        @(negedge clk); instr_addr_i = 32'h102; #1;
        checks++; if (instr_rvalid_o !== 1'b1) $display("FAIL ws_rvalid_n4 got=%b want=1", instr_rvalid_o); else passes++;
        checks++; if (haddr_o !== 32'h100) $display("FAIL misaligned_haddr got=%h want=00000100", haddr_o); else passes++;
        @(negedge clk); instr_req_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (instr_rvalid_o !== 1'b0) $display("FAIL ws_rvalid_done got=%b want=0", instr_rvalid_o); else passes++;
    endtask

    task automatic test_error();
        err_addr = 32'h200;
        @(negedge clk); instr_req_i = 1'b1; instr_addr_i = 32'h200; #1;
        checks++; if (instr_gnt_o !== 1'b1) $display("FAIL err_gnt0 got=%b want=1", instr_gnt_o); else passes++;
        @(negedge clk); instr_addr_i = 32'h204; hready_i = 1'b0; hresp_i = 1'b1; #1;
        checks++; if (htrans_o !== (ERR ? 2'b00 : 2'b10)) $display("FAIL err_c1_htrans got=%b want=%b", htrans_o, ERR ? 2'b00 : 2'b10); else passes++;
        checks++; if (instr_gnt_o !== 1'b0) $display("FAIL err_c1_gnt got=%b want=0", instr_gnt_o); else passes++;
        @(negedge clk); hready_i = 1'b1; #1;
        checks++; if (instr_gnt_o !== !ERR) $display("FAIL err_c2_gnt got=%b want=%b", instr_gnt_o, !ERR); else passes++;
        @(negedge clk); hresp_i = 1'b0; instr_req_i = 1'b0; #1;
        checks++; if (instr_rvalid_o !== 1'b1) $display("FAIL err_rvalid got=%b want=1", instr_rvalid_o); else passes++;
        checks++; if (instr_err_o !== ERR) $display("FAIL err_flag got=%b want=%b", instr_err_o, ERR); else passes++;
        checks++; if (instr_rdata_o !== (ERR ? 32'h0 : mem(32'h200))) $display("FAIL err_rdata got=%h want=%h", instr_rdata_o, ERR ? 32'h0 : mem(32'h200)); else passes++;
        repeat (3) @(negedge clk);
        err_addr = 32'h1;
    endtask

    task automatic test_reset_mid();
        @(negedge clk); instr_req_i = 1'b1; instr_addr_i = 32'h300; #1;
        checks++; if (instr_gnt_o !== 1'b1) $display("FAIL rmid_gnt got=%b want=1", instr_gnt_o); else passes++;
        @(negedge clk); instr_req_i = 1'b0; hready_i = 1'b0; #1;
        checks++; if (instr_rvalid_o !== 1'b0) $display("FAIL rmid_rvalid_wait got=%b want=0", instr_rvalid_o); else passes++;
        @(negedge clk); rstn = 1'b0; exp_q.delete();
        @(negedge clk); rstn = 1'b1; hready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++; if (instr_rvalid_o !== 1'b0) $display("FAIL rmid_rvalid cyc=%0d got=%b want=0", i, instr_rvalid_o); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_reset_mid();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        checks++; if (exp_q.size() != 0) $display("FAIL sb_drain got=%0d pending want=0", exp_q.size()); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end
endmodule
